// File: rtl/card_record_writer_if.sv
// Signal bundle between the card record writer and its neighbours:
// allocator handshake, payload stream, RAM write port and completion report.
`timescale 1ns/1ps
interface card_record_writer_if;
    logic        start;
    logic        alloc_en;
    logic        alloc_found;
    logic [9:0]  alloc_addr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        done;
    logic [9:0]  rec_addr;
    logic [4:0]  rec_len;
    logic        overflow;
    logic        error;

    modport slave (
        input  start, alloc_found, alloc_addr, in_data, in_valid, in_last,
        output alloc_en, in_ready, ram_addr, ram_data, ram_wren,
               done, rec_addr, rec_len, overflow, error
    );

    modport master (
        output start, alloc_found, alloc_addr, in_data, in_valid, in_last,
        input  alloc_en, in_ready, ram_addr, ram_data, ram_wren,
               done, rec_addr, rec_len, overflow, error
    );
endinterface

// File: rtl/card_record_writer.sv
// Requests a 32-word slot, streams payload into base+1.., then seals the slot
// by writing the header word at base+0 last.
`timescale 1ns/1ps
module card_record_writer #(
    parameter int ALLOC_TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 resetn,
    card_record_writer_if.slave  bus
);
    localparam int             CW          = $clog2(ALLOC_TIMEOUT + 1);
    localparam logic [CW-1:0]  TIMEOUT_LIM = CW'(ALLOC_TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, HDR, FIN} state_t;

    state_t        state_q, state_d;
    logic [9:0]    base_q, base_d;
    logic [4:0]    n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fail_q, fail_d;

    // Decisions land in the pend stage first; the output registers copy it a
    // cycle later, so RAM writes and done trail the state machine uniformly.
    logic          pend_wr_q, pend_wr_d;
    logic [9:0]    pend_addr_q, pend_addr_d;
    logic [31:0]   pend_data_q, pend_data_d;
    logic          pend_done_q, pend_done_d;
    logic          pend_err_q, pend_err_d;

    logic          alloc_en_q, alloc_en_d;
    logic          in_ready_q, in_ready_d;
    logic          ram_wren_q;
    logic [9:0]    ram_addr_q;
    logic [31:0]   ram_data_q;
    logic          done_q;
    logic [9:0]    rec_addr_q, rec_addr_d;
    logic [4:0]    rec_len_q, rec_len_d;
    logic          overflow_q, overflow_d;
    logic          error_q, error_d;

    logic          accept;
    assign accept = in_ready_q & bus.in_valid;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        pend_wr_d   = 1'b0;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        pend_done_d = 1'b0;
        pend_err_d  = 1'b0;
        rec_addr_d  = rec_addr_q;
        rec_len_d   = rec_len_q;
        overflow_d  = overflow_q;
        error_d     = error_q;

        if (pend_done_q && pend_err_q) error_d = 1'b1;

        case (state_q)
            IDLE: if (bus.start) begin
                state_d    = REQ;
                n_d        = '0;
                cnt_d      = '0;
                fail_d     = 1'b0;
                overflow_d = 1'b0;
                error_d    = 1'b0;
                rec_len_d  = '0;
            end
            REQ: state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // cnt_q is still zero in the first WAIT cycle, when found is stale.
                if (cnt_q != '0 && bus.alloc_found) begin
                    base_d = bus.alloc_addr;
                    if (bus.alloc_addr[4:0] != 5'd0) begin
                        fail_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        state_d = STREAM;
                    end
                end else if (cnt_d == TIMEOUT_LIM) begin
                    fail_d  = 1'b1;
                    state_d = FIN;
                end
            end
            STREAM: if (accept) begin
                if (n_q != 5'd31) begin
                    pend_wr_d   = 1'b1;
                    pend_addr_d = base_q + 10'(n_q) + 10'd1;
                    pend_data_d = bus.in_data;
                    n_d         = n_q + 5'd1;
                end else begin
                    overflow_d = 1'b1;
                end
                if (bus.in_last) state_d = HDR;
            end
            HDR: begin
                pend_wr_d   = 1'b1;
                pend_addr_d = base_q;
                pend_data_d = {1'b1, 26'd0, n_q};
                rec_len_d   = n_q;
                rec_addr_d  = base_q;
                state_d     = FIN;
            end
            FIN: begin
                pend_done_d = 1'b1;
                pend_err_d  = fail_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        alloc_en_d = (state_q == REQ);
        in_ready_d = (state_d == STREAM);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            base_q      <= '0;
            n_q         <= '0;
            cnt_q       <= '0;
            fail_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            pend_done_q <= 1'b0;
            pend_err_q  <= 1'b0;
            alloc_en_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            ram_wren_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            done_q      <= 1'b0;
            rec_addr_q  <= '0;
            rec_len_q   <= '0;
            overflow_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            pend_wr_q   <= pend_wr_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            pend_done_q <= pend_done_d;
            pend_err_q  <= pend_err_d;
            alloc_en_q  <= alloc_en_d;
            in_ready_q  <= in_ready_d;
            ram_wren_q  <= pend_wr_q;
            ram_addr_q  <= pend_addr_q;
            ram_data_q  <= pend_data_q;
            done_q      <= pend_done_q;
            rec_addr_q  <= rec_addr_d;
            rec_len_q   <= rec_len_d;
            overflow_q  <= overflow_d;
            error_q     <= error_d;
        end
    end

    assign bus.alloc_en = alloc_en_q;
    assign bus.in_ready = in_ready_q;
    assign bus.ram_wren = ram_wren_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    assign bus.done     = done_q;
    assign bus.rec_addr = rec_addr_q;
    assign bus.rec_len  = rec_len_q;
    assign bus.overflow = overflow_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_card_record_writer.sv
// Randomised record traffic against a list-of-writes reference model, plus
// directed timeout, stale/misaligned grant and mid-stream reset cases.
`timescale 1ns/1ps
module tb_card_record_writer;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    card_record_writer_if bus ();

    card_record_writer #(.ALLOC_TIMEOUT(64)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed RAM writes, captured away from the active edge.
    logic [9:0]  wa[$];
    logic [31:0] wd[$];
    int          wc[$];
    bit          ready_seen = 1'b0;
    always @(negedge clock) begin
        if (bus.ram_wren) begin
            wa.push_back(bus.ram_addr);
            wd.push_back(bus.ram_data);
            wc.push_back(cyc);
        end
        if (bus.in_ready) ready_seen = 1'b1;
    end

    logic [31:0] words [64];
    int start_cyc, done_cyc;

    function automatic logic [63:0] outs();
        return 64'({bus.alloc_en, bus.in_ready, bus.ram_wren, bus.ram_addr, bus.ram_data,
                    bus.done, bus.rec_addr, bus.rec_len, bus.overflow, bus.error});
    endfunction

    task automatic wait_done(input int budget, output bit seen, output int dcyc, output bit err_before);
        seen = 1'b0; dcyc = 0; err_before = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (bus.done) begin seen = 1'b1; dcyc = cyc; end
            else err_before = bus.error;
        end
    endtask

    // vmode: 0 valid always, 1 toggling, 2 random.  rst_after>0 resets after that many beats.
    task automatic run_record(input logic [9:0] base, input int nbeats, input int vmode,
                              input int fdelay, input bit stale, input bit tmo, input int rst_after);
        int idx, last_cyc, rise_cyc, wait_entry, len, hdr_hits;
        bit ready_drv, seen, eb;
        logic [9:0]  ea[$];
        logic [31:0] ed[$];

        wa.delete(); wd.delete(); wc.delete();
        @(negedge clock);
        bus.start = 1'b1;
        ready_seen = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        start_cyc = cyc;
        check("flags_cleared", 64'({bus.error, bus.overflow}), 64'd0);

        rise_cyc = -1;
        for (int i = 0; i < 4 && rise_cyc < 0; i++) begin
            if (i > 0) @(negedge clock);
            if (bus.alloc_en) rise_cyc = cyc;
        end
        check("alloc_en_rise", 64'(rise_cyc - start_cyc), 64'd1);
        if (stale) begin
            bus.alloc_found = 1'b1;
            bus.alloc_addr  = 10'h100;
        end
        @(negedge clock);
        check("alloc_en_width", 64'(bus.alloc_en), 64'd0);
        wait_entry = cyc;

        if (tmo) begin
            wait_done(120, seen, done_cyc, eb);
            check("tmo_done_seen", 64'(seen), 64'd1);
            check("tmo_latency", 64'(done_cyc - wait_entry), 64'd65);
            check("tmo_error", 64'({eb, bus.error}), 64'b01);
            check("tmo_no_writes", 64'(wa.size()), 64'd0);
            check("tmo_no_ready", 64'(ready_seen), 64'd0);
            @(negedge clock);
            check("tmo_done_pulse", 64'(bus.done), 64'd0);
            return;
        end

        if (fdelay > 0) begin
            bus.alloc_found = 1'b0;
            repeat (fdelay) @(negedge clock);
        end
        bus.alloc_found = 1'b1;
        bus.alloc_addr  = base;

        if (base[4:0] != 5'd0) begin
            @(negedge clock);
            bus.alloc_found = 1'b0;
            wait_done(10, seen, done_cyc, eb);
            check("misal_done_seen", 64'(seen), 64'd1);
            check("misal_error", 64'(bus.error), 64'd1);
            check("misal_no_writes", 64'(wa.size()), 64'd0);
            check("misal_no_ready", 64'(ready_seen), 64'd0);
            return;
        end

        idx = 0; ready_drv = 1'b0; last_cyc = 0;
        for (int t = 0; t < 600 && idx < nbeats; t++) begin
            @(negedge clock);
            bus.alloc_found = 1'b0;
            if (bus.in_valid && ready_drv) begin idx++; last_cyc = cyc; end
            if (rst_after > 0 && idx == rst_after) begin
                resetn = 1'b0;
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                #1;
                check("rst_outputs_zero", outs(), 64'd0);
                @(negedge clock);
                @(negedge clock);
                resetn = 1'b1;
                ready_seen = 1'b0;
                repeat (4) @(negedge clock);
                hdr_hits = 0;
                foreach (wa[i]) if (wa[i] == base) hdr_hits++;
                check("rst_no_header", 64'(hdr_hits), 64'd0);
                check("rst_idle_ready", 64'(ready_seen), 64'd0);
                check("rst_idle_done", 64'(bus.done), 64'd0);
                return;
            end
            if (idx < nbeats) begin
                case (vmode)
                    0:       bus.in_valid = 1'b1;
                    1:       bus.in_valid = (t % 2) == 1;
                    default: bus.in_valid = ($urandom % 3) != 0;
                endcase
                bus.in_data = words[idx];
                bus.in_last = (idx == nbeats - 1);
                ready_drv   = bus.in_ready;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end
        end
        check("beats_accepted", 64'(idx), 64'(nbeats));

        wait_done(20, seen, done_cyc, eb);
        check("done_seen", 64'(seen), 64'd1);
        check("done_latency", 64'(done_cyc - last_cyc), 64'd3);

        // Reference: stored payload words in order, then the sealing header.
        len = (nbeats > 31) ? 31 : nbeats;
        for (int i = 0; i < len; i++) begin
            ea.push_back(base + 10'(i + 1));
            ed.push_back(words[i]);
        end
        ea.push_back(base);
        ed.push_back(32'h8000_0000 | 32'(len));

        check("wr_count", 64'(wa.size()), 64'(ea.size()));
        for (int i = 0; i < ea.size() && i < wa.size(); i++)
            check($sformatf("wr%0d", i), 64'({wa[i], wd[i]}), 64'({ea[i], ed[i]}));
        if (wc.size() > 0) check("hdr_latency", 64'(wc[wc.size()-1] - last_cyc), 64'd2);
        check("rec_addr", 64'(bus.rec_addr), 64'(base));
        check("rec_len", 64'(bus.rec_len), 64'(len));
        check("flags", 64'({bus.overflow, bus.error}), 64'({nbeats > 31, 1'b0}));
        @(negedge clock);
        check("done_pulse", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.alloc_found = 1'b0; bus.alloc_addr = '0;
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", outs(), 64'd0);
        resetn = 1'b1;
        @(negedge clock);
        check("idle_outputs", outs(), 64'd0);

        words[0] = 32'h0000_000A; words[1] = 32'h0000_000B; words[2] = 32'h0000_000C;
        run_record(10'h040, 3, 0, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 64; i++) words[i] = $urandom;
        run_record(10'h020, 2, 1, 0, 1'b0, 1'b0, 0);
        run_record(10'h3E0, 35, 0, 0, 1'b0, 1'b0, 0);
        run_record(10'h180, 1, 0, 0, 1'b0, 1'b0, 0);
        check("min_start_to_done", 64'(done_cyc - start_cyc), 64'd7);

        run_record(10'h000, 1, 0, 0, 1'b0, 1'b1, 0);
        run_record(10'h045, 1, 0, 0, 1'b1, 1'b0, 0);
        run_record(10'h0C0, 4, 0, 0, 1'b0, 1'b0, 2);
        run_record(10'h0C0, 4, 0, 0, 1'b0, 1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 64; i++) words[i] = $urandom;
            run_record(10'($urandom_range(0, 31)) << 5, $urandom_range(1, 40), 2,
                       $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
